// File: rtl/axi_test_phase_sequencer_if.sv
// Sequencer control bus: start/loop request, phase start pulses,
// done latches from the phase engines and status.
interface axi_test_phase_sequencer_if #(
  parameter int LOOP_WIDTH = 8
);
  logic                  seq_start;
  logic [LOOP_WIDTH-1:0] seq_loops;
  logic                  write_phase_start;
  logic                  read_phase_start;
  logic                  byte_verification_phase_start;
  logic                  write_phase_done_latched;
  logic                  read_phase_done_latched;
  logic                  byte_verification_phase_done_latched;
  logic                  clear_phase_latches;
  logic                  seq_busy;
  logic                  seq_done;
  logic                  seq_timeout;
  logic [1:0]            current_phase;
  logic [LOOP_WIDTH-1:0] loop_counter;

  modport master (
    output seq_start, seq_loops,
    output write_phase_done_latched, read_phase_done_latched,
    output byte_verification_phase_done_latched,
    input  write_phase_start, read_phase_start,
    input  byte_verification_phase_start, clear_phase_latches,
    input  seq_busy, seq_done, seq_timeout,
    input  current_phase, loop_counter
  );

  modport slave (
    input  seq_start, seq_loops,
    input  write_phase_done_latched, read_phase_done_latched,
    input  byte_verification_phase_done_latched,
    output write_phase_start, read_phase_start,
    output byte_verification_phase_start, clear_phase_latches,
    output seq_busy, seq_done, seq_timeout,
    output current_phase, loop_counter
  );
endinterface

// File: rtl/axi_test_phase_sequencer.sv
// Runs WRITE -> READ -> BYTE_VERIFY phases for a number of passes,
// with a per-phase watchdog. All outputs are registered.
module axi_test_phase_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LOOP_WIDTH     = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  axi_test_phase_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [1:0]            phase, phase_n;
  logic [LOOP_WIDTH-1:0] lcnt, lcnt_n;
  logic [LOOP_WIDTH-1:0] loops, loops_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic                  busy, busy_n;
  logic                  done, done_n;
  logic                  tout, tout_n;
  logic                  clr, clr_n;
  logic [2:0]            start, start_n;
  logic                  fire;
  logic                  hit;
  logic [LOOP_WIDTH:0]   lcnt_inc;
  logic                  last_pass;

  // Select the done latch belonging to the active phase.
  always_comb begin
    hit = 1'b0;
    case (phase)
      2'd0:    hit = bus.write_phase_done_latched;
      2'd1:    hit = bus.read_phase_done_latched;
      2'd2:    hit = bus.byte_verification_phase_done_latched;
      default: hit = 1'b0;
    endcase
  end

  assign lcnt_inc  = {1'b0, lcnt} + 1'b1;
  assign last_pass = (lcnt_inc == {1'b0, loops});

  // Next-state and next-output logic; pulses are computed one cycle ahead.
  always_comb begin
    state_n = state;
    phase_n = phase;
    lcnt_n  = lcnt;
    loops_n = loops;
    tcnt_n  = tcnt;
    busy_n  = busy;
    done_n  = done;
    tout_n  = tout;
    clr_n   = 1'b0;
    fire    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.seq_start) begin
          state_n = S_START;
          phase_n = 2'd0;
          lcnt_n  = '0;
          loops_n = (bus.seq_loops == '0) ?
                    LOOP_WIDTH'(1) : bus.seq_loops;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          tout_n  = 1'b0;
          fire    = 1'b1;
        end
      end
      S_START: begin
        state_n = S_WAIT;
        tcnt_n  = '0;
      end
      S_WAIT: begin
        if (hit) begin
          state_n = S_CLEAR;
          clr_n   = 1'b1;
        end else if (tcnt == T_LAST) begin
          state_n = S_ERROR;
          tout_n  = 1'b1;
          busy_n  = 1'b0;
          clr_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      S_CLEAR: begin
        if (phase != 2'd2) begin
          phase_n = phase + 2'd1;
          state_n = S_START;
          fire    = 1'b1;
        end else begin
          lcnt_n = (&lcnt) ? lcnt : lcnt_inc[LOOP_WIDTH-1:0];
          if (last_pass) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            phase_n = 2'd0;
            state_n = S_START;
            fire    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        phase_n = 2'd0;
        lcnt_n  = '0;
        loops_n = '0;
        tcnt_n  = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        tout_n  = 1'b0;
      end
    endcase
    start_n = {fire && (phase_n == 2'd2),
               fire && (phase_n == 2'd1),
               fire && (phase_n == 2'd0)};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= 2'd0;
      lcnt  <= '0;
      loops <= '0;
      tcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tout  <= 1'b0;
      clr   <= 1'b0;
      start <= 3'b000;
    end else begin
      state <= state_n;
      phase <= phase_n;
      lcnt  <= lcnt_n;
      loops <= loops_n;
      tcnt  <= tcnt_n;
      busy  <= busy_n;
      done  <= done_n;
      tout  <= tout_n;
      clr   <= clr_n;
      start <= start_n;
    end
  end

  assign bus.write_phase_start             = start[0];
  assign bus.read_phase_start              = start[1];
  assign bus.byte_verification_phase_start = start[2];
  assign bus.clear_phase_latches           = clr;
  assign bus.seq_busy                      = busy;
  assign bus.seq_done                      = done;
  assign bus.seq_timeout                   = tout;
  assign bus.current_phase                 = phase;
  assign bus.loop_counter                  = lcnt;
endmodule

// File: tb/tb_axi_test_phase_sequencer.sv
// Scoreboard bench for axi_test_phase_sequencer: expected events are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_axi_test_phase_sequencer;
  localparam int LW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] lat;

  axi_test_phase_sequencer_if #(.LOOP_WIDTH(LW)) bus ();

  axi_test_phase_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .LOOP_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.write_phase_done_latched             = lat[0];
  assign bus.read_phase_done_latched              = lat[1];
  assign bus.byte_verification_phase_done_latched = lat[2];

  // kind: 0/1/2 start W/R/B, 3 clear, 4 seq_done rise, 5 timeout rise
  typedef struct {
    int kind;
    int gap;
    int phase;
    int lcnt;
  } ev_t;

  ev_t  sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ref_cyc = 0;
  int   dly[3];
  int   cnt[3];
  logic done_q;
  logic tout_q;

  function automatic string kname(input int k);
    case (k)
      0: return "start_w";
      1: return "start_r";
      2: return "start_b";
      3: return "clear";
      4: return "done";
      5: return "timeout";
      default: return "none";
    endcase
  endfunction

  task automatic push(input int k, input int g, input int ph, input int lc);
    ev_t e;
    e.kind = k;
    e.gap = g;
    e.phase = ph;
    e.lcnt = lc;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    int g;
    int ph;
    int lc;
    g = cyc - ref_cyc;
    ph = int'(bus.current_phase);
    lc = int'(bus.loop_counter);
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got event gap=%0d, expected none",
               kname(k), g);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.gap != g ||
          (k >= 4 && (e.phase != ph || e.lcnt != lc))) begin
        n_fail++;
        $display("FAIL event_%s: got %s gap=%0d ph=%0d lc=%0d, expected %s gap=%0d ph=%0d lc=%0d",
                 kname(e.kind), kname(k), g, ph, lc,
                 kname(e.kind), e.gap, e.phase, e.lcnt);
      end
    end
    if (k <= 2) ref_cyc = cyc;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every observable DUT event is matched against the queue.
  always @(negedge clk) begin
    if (bus.seq_start === 1'b1 && bus.seq_busy === 1'b0) ref_cyc = cyc;
    if (bus.clear_phase_latches === 1'b1) check_ev(3);
    if (bus.write_phase_start === 1'b1) check_ev(0);
    if (bus.read_phase_start === 1'b1) check_ev(1);
    if (bus.byte_verification_phase_start === 1'b1) check_ev(2);
    if (bus.seq_done === 1'b1 && done_q !== 1'b1) check_ev(4);
    if (bus.seq_timeout === 1'b1 && tout_q !== 1'b1) check_ev(5);
    done_q = bus.seq_done;
    tout_q = bus.seq_timeout;
  end

  // Phase-engine model: sticky done latch raised dly cycles after start.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      lat = 3'b000;
      for (int p = 0; p < 3; p++) cnt[p] = 0;
    end else begin
      if (bus.clear_phase_latches === 1'b1) lat = 3'b000;
      for (int p = 0; p < 3; p++) begin
        if (cnt[p] > 0) begin
          cnt[p]--;
          if (cnt[p] == 0) lat[p] = 1'b1;
        end
      end
      if (bus.write_phase_start === 1'b1) cnt[0] = dly[0];
      if (bus.read_phase_start === 1'b1) cnt[1] = dly[1];
      if (bus.byte_verification_phase_start === 1'b1) cnt[2] = dly[2];
    end
  end

  // Successful sequence: start gap is prior done delay + 2 cycles.
  task automatic expect_seq(input int eff, input int d0, input int d1,
                            input int d2);
    int d[3];
    int g;
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    g = 1;
    for (int n = 0; n < eff; n++) begin
      for (int p = 0; p < 3; p++) begin
        push(p, g, 0, 0);
        push(3, d[p] + 1, 0, 0);
        g = d[p] + 2;
      end
    end
    push(4, g, 2, eff);
  endtask

  task automatic run(input int loops, input int d0, input int d1,
                     input int d2);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    @(posedge clk);
    #1;
    bus.seq_loops = LW'(loops);
    bus.seq_start = 1'b1;
    @(posedge clk);
    #1;
    bus.seq_start = 1'b0;
  endtask

  task automatic drain(input string nm, input int idle);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 500) begin
      @(posedge clk);
      i++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d pending events, expected 0",
               nm, sb.size());
      sb.delete();
    end
    repeat (idle) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, int'(bus.seq_busy), 0);
    chk({nm, "_done"}, int'(bus.seq_done), 0);
    chk({nm, "_tout"}, int'(bus.seq_timeout), 0);
    chk({nm, "_phase"}, int'(bus.current_phase), 0);
    chk({nm, "_lcnt"}, int'(bus.loop_counter), 0);
    chk({nm, "_pulses"}, int'({bus.write_phase_start,
        bus.read_phase_start, bus.byte_verification_phase_start,
        bus.clear_phase_latches}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dly[0] = 0;
    dly[1] = 0;
    dly[2] = 0;
    rst_n = 1'b0;
    bus.seq_start = 1'b0;
    bus.seq_loops = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    expect_seq(1, 5, 5, 5);
    run(1, 5, 5, 5);
    drain("loops1", 10);
    chk("loops1_busy", int'(bus.seq_busy), 0);

    expect_seq(1, 5, 5, 5);
    run(0, 5, 5, 5);
    drain("loops0", 10);
    chk("loops0_done", int'(bus.seq_done), 1);

    expect_seq(3, 1, 1, 1);
    run(3, 1, 1, 1);
    drain("loops3", 10);
    chk("loops3_lcnt", int'(bus.loop_counter), 3);

    push(0, 1, 0, 0);
    push(3, 2, 0, 0);
    push(1, 3, 0, 0);
    push(3, 17, 0, 0);
    push(5, 17, 1, 0);
    run(1, 1, 0, 1);
    drain("timeout", 30);
    chk("timeout_busy", int'(bus.seq_busy), 0);
    chk("timeout_done", int'(bus.seq_done), 0);

    expect_seq(1, 1, 16, 1);
    run(1, 1, 16, 1);
    drain("edge", 10);
    chk("edge_tout", int'(bus.seq_timeout), 0);

    push(0, 1, 0, 0);
    push(3, 2, 0, 0);
    push(1, 3, 0, 0);
    push(3, 2, 0, 0);
    push(2, 3, 0, 0);
    run(1, 1, 1, 0);
    drain("prereset", 2);
    bus.seq_loops = LW'(5);
    bus.seq_start = 1'b1;
    @(posedge clk);
    #1;
    bus.seq_start = 1'b0;
    chk("busy_start_busy", int'(bus.seq_busy), 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("midreset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_zero("postreset");

    expect_seq(1, 1, 1, 1);
    run(1, 1, 1, 1);
    drain("restart", 10);
    chk("restart_lcnt", int'(bus.loop_counter), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
